gcapply: RTL

Gain-curve applicator for the spectral path. Streams FFT bins, reads the per-bin gain from the gain curve RAM (read port), multiplies real and imaginary parts by that gain, saturates, and forwards bins to the IFFT. It is the consumer of the gain curve memory written by the curve-reset and curve-edit logic. It bypasses to unity gain while a curve rewrite is in progress.

---
 rtl/gcapply.sv | 111 +++++++++++
 1 files changed

// File: rtl/gcapply.sv
// Gain-curve applicator: scales streamed FFT bins by a per-bin gain read from the
// curve RAM, with unity bypass while the curve is being rewritten.
module gcapply #(
  parameter int LOGFFTSIZE = 13,
  parameter int AUDIOWIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [LOGFFTSIZE-1:0]        in_index,
  input  logic signed [AUDIOWIDTH-1:0] in_re,
  input  logic signed [AUDIOWIDTH-1:0] in_im,
  input  logic                         gc_busy,
  output logic [LOGFFTSIZE-1:0]        gcurve_addr,
  input  logic [AUDIOWIDTH-1:0]        gcurve_dout,
  input  logic                         clr_stats,
  output logic                         out_valid,
  output logic [LOGFFTSIZE-1:0]        out_index,
  output logic signed [AUDIOWIDTH-1:0] out_re,
  output logic signed [AUDIOWIDTH-1:0] out_im,
  output logic                         out_last,
  output logic [15:0]                  sat_count
);

  localparam int W  = AUDIOWIDTH;
  localparam int PW = 2 * W + 1;
  localparam logic [W-1:0] UNITY = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [PW-1:0] MAX_POS = (PW'(1) <<< (W-1)) - PW'(1);
  localparam logic signed [PW-1:0] MIN_NEG = -(PW'(1) <<< (W-1));
  localparam logic [LOGFFTSIZE-1:0] LAST_IDX = '1;

  logic                        s1_valid_reg;
  logic                        s1_busy_reg;
  logic [LOGFFTSIZE-1:0]       s1_index_reg;
  logic signed [W-1:0]         s1_data_reg [2];
  logic                        s2_valid_reg;
  logic [LOGFFTSIZE-1:0]       s2_index_reg;
  logic signed [PW-1:0]        s2_prod_reg [2];

  logic [W-1:0]                gain;
  logic signed [PW-1:0]        prod_next [2];
  logic signed [W-1:0]         sat_data [2];
  logic [1:0]                  sat_flag;
  logic [16:0]                 sat_sum;
  logic [15:0]                 sat_count_next;

  assign gcurve_addr = in_index;
  // The RAM answers for the stage-1 bin, so the busy flag must come from stage 1 too.
  assign gain = s1_busy_reg ? UNITY : gcurve_dout;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_comp
      logic signed [PW-1:0] shifted;
      logic                 over_hi;
      logic                 over_lo;

      assign prod_next[gi] = PW'(s1_data_reg[gi]) * PW'($signed({1'b0, gain}));
      assign shifted       = s2_prod_reg[gi] >>> (W - 1);
      assign over_hi       = shifted > MAX_POS;
      assign over_lo       = shifted < MIN_NEG;
      assign sat_data[gi]  = over_hi ? MAX_VAL : (over_lo ? MIN_VAL : shifted[W-1:0]);
      // Bubbles carry stale products, so only valid bins may count saturations.
      assign sat_flag[gi]  = s2_valid_reg & (over_hi | over_lo);
    end
  endgenerate

  assign sat_sum        = {1'b0, sat_count} + 17'(sat_flag[0]) + 17'(sat_flag[1]);
  assign sat_count_next = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg   <= 1'b0;
      s1_busy_reg    <= 1'b0;
      s1_index_reg   <= '0;
      s1_data_reg[0] <= '0;
      s1_data_reg[1] <= '0;
      s2_valid_reg   <= 1'b0;
      s2_index_reg   <= '0;
      s2_prod_reg[0] <= '0;
      s2_prod_reg[1] <= '0;
      out_valid      <= 1'b0;
      out_index      <= '0;
      out_re         <= '0;
      out_im         <= '0;
      out_last       <= 1'b0;
      sat_count      <= '0;
    end else begin
      s1_valid_reg   <= in_valid;
      s1_busy_reg    <= gc_busy;
      s1_index_reg   <= in_index;
      s1_data_reg[0] <= in_re;
      s1_data_reg[1] <= in_im;

      s2_valid_reg   <= s1_valid_reg;
      s2_index_reg   <= s1_index_reg;
      s2_prod_reg[0] <= prod_next[0];
      s2_prod_reg[1] <= prod_next[1];

      out_valid <= s2_valid_reg;
      out_index <= s2_index_reg;
      out_re    <= sat_data[0];
      out_im    <= sat_data[1];
      out_last  <= s2_valid_reg && (s2_index_reg == LAST_IDX);

      sat_count <= clr_stats ? 16'h0000 : sat_count_next;
    end
  end

endmodule
